// File: rtl/fmc_i2c_init_sequencer.sv
// Steps through a table of I2C register writes and hands each one to the byte-level
// I2C engine. NACKs are retried after a gap, a silent engine times out, and done/error are sticky.
module fmc_i2c_init_sequencer #(
   parameter int NUM_ENTRIES    = 4,
   parameter int MAX_RETRIES    = 3,
   parameter int RETRY_GAP      = 1000,
   parameter int TIMEOUT_CYCLES = 200000,
   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic             CLK,
   input  logic             rst,
   input  logic             start,
   output logic [IDX_W-1:0] tbl_idx,
   input  logic [6:0]       tbl_dev_addr,
   input  logic [7:0]       tbl_reg,
   input  logic [7:0]       tbl_data,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [6:0]       cmd_dev_addr,
   output logic [7:0]       cmd_reg,
   output logic [7:0]       cmd_data,
   input  logic             rsp_valid,
   input  logic             rsp_nack,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [1:0]       err_code,
   output logic [IDX_W-1:0] err_idx
);

   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP + 1) : 1;
   localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RETRY_GAP - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [2:0] {
      IDLE, FETCH, ISSUE, WAIT_RSP, BACKOFF, NEXT
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [RTY_W-1:0] retry_cnt;
   logic [TMR_W-1:0] timer;
   logic [GAP_W-1:0] gap_cnt;

   assign tbl_idx = idx;

   always_ff @(posedge CLK) begin
      if (!rst) begin
         state        <= IDLE;
         idx          <= '0;
         retry_cnt    <= '0;
         timer        <= '0;
         gap_cnt      <= '0;
         cmd_valid    <= 1'b0;
         cmd_dev_addr <= '0;
         cmd_reg      <= '0;
         cmd_data     <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         err_code     <= 2'b00;
         err_idx      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  done      <= 1'b0;
                  error     <= 1'b0;
                  err_code  <= 2'b00;
                  err_idx   <= '0;
                  idx       <= '0;
                  retry_cnt <= '0;
                  busy      <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               cmd_dev_addr <= tbl_dev_addr;
               cmd_reg      <= tbl_reg;
               cmd_data     <= tbl_data;
               cmd_valid    <= 1'b1;
               state        <= ISSUE;
            end
            ISSUE: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  timer     <= '0;
                  state     <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               // A response arriving on the timeout cycle takes priority over the timeout.
               if (rsp_valid) begin
                  if (!rsp_nack) begin
                     state <= NEXT;
                  end else if (retry_cnt < RTY_MAX) begin
                     retry_cnt <= retry_cnt + RTY_W'(1);
                     gap_cnt   <= '0;
                     state     <= BACKOFF;
                  end else begin
                     error    <= 1'b1;
                     err_code <= 2'b01;
                     err_idx  <= idx;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end
               end else if (timer == TMR_LAST) begin
                  error    <= 1'b1;
                  err_code <= 2'b10;
                  err_idx  <= idx;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            BACKOFF: begin
               // Reissue the already latched command; the table is not read again.
               if (gap_cnt == GAP_LAST) begin
                  cmd_valid <= 1'b1;
                  state     <= ISSUE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            NEXT: begin
               if (idx == IDX_LAST) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx       <= idx + IDX_W'(1);
                  retry_cnt <= '0;
                  state     <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
